// File: rtl/lcd1602_pkg.sv
// Shared LCD1602 definitions: HD44780 command bytes, bus scheduler state encoding
// and the power-up init command table.
package lcd1602_pkg;

  localparam logic [7:0] CLEAR_DISPLAY             = 8'h01;
  localparam logic [7:0] SHIFT_CURSOR_RIGHT        = 8'h06;
  localparam logic [7:0] DISPON_CURSOROFF          = 8'h0C;
  localparam logic [7:0] LINES2_MATRIX5x8_MODE8bit = 8'h38;
  localparam logic [7:0] START_2LINE               = 8'hC0;

  localparam logic [2:0] INIT_LEN = 3'd5;

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_INIT    = 3'd1,
    S_IDLE    = 3'd2,
    S_OWNED   = 3'd3,
    S_GAP     = 3'd4
  } sched_state_e;

  // Function set is issued twice so an 8-bit bus is latched whatever mode the
  // controller woke up in.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = LINES2_MATRIX5x8_MODE8bit;
      3'd1:    init_cmd = LINES2_MATRIX5x8_MODE8bit;
      3'd2:    init_cmd = DISPON_CURSOROFF;
      3'd3:    init_cmd = CLEAR_DISPLAY;
      3'd4:    init_cmd = SHIFT_CURSOR_RIGHT;
      default: init_cmd = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lcd1602_bus_sched_if.sv
// Client side of the LCD bus scheduler: per-client request, rs, data byte and
// the one-hot grant returned by the scheduler.
interface lcd1602_bus_sched_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rs;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;

  modport master (output req, output req_rs, output req_data, input grant);
  modport slave  (input req, input req_rs, input req_data, output grant);
endinterface

// File: rtl/lcd1602_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr wins,
// so the client at ptr has lowest priority.
module lcd1602_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   win_idx,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    valid   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        win_idx     = idx;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd1602_bus_sched.sv
// LCD1602 bus owner: HD44780 power-up/init, then round-robin bus grants to
// painter clients with a hold watchdog.
//
// state   | meaning
// POWERUP | bus idle for POWERUP_TICKS after reset
// INIT    | one init command per tick, then init_done
// IDLE    | waiting for a request, arbitrates
// OWNED   | granted client drives rs/data directly
// GAP     | one dead tick between release and next grant
module lcd1602_bus_sched
  import lcd1602_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int POWERUP_TICKS = 3,
  parameter int MAX_HOLD      = 255
) (
  input  logic                clk_16ms,
  input  logic                reset,
  lcd1602_bus_sched_if.slave  bus,
  output logic                init_done,
  output logic                timeout_err,
  output logic                rs,
  output logic                rw,
  output logic [7:0]          data
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int PU_W   = $clog2(POWERUP_TICKS + 1);

  sched_state_e       state;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] blocked;
  logic [7:0]         data_q;
  logic [PU_W-1:0]    pu_cnt;
  logic [2:0]         init_idx;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;

  logic [NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]   win_idx;
  logic               win_valid;
  logic               owned;

  // A client revoked by the watchdog stays out of arbitration until it drops req.
  lcd1602_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (bus.req & ~blocked),
    .ptr     (ptr),
    .winner  (win_onehot),
    .win_idx (win_idx),
    .valid   (win_valid)
  );

  always_ff @(posedge clk_16ms) begin
    if (!reset) begin
      state       <= S_POWERUP;
      grant_q     <= '0;
      blocked     <= '0;
      init_done   <= 1'b0;
      timeout_err <= 1'b0;
      data_q      <= 8'h00;
      pu_cnt      <= '0;
      init_idx    <= '0;
      hold_cnt    <= '0;
      ptr         <= PTR_W'(NUM_REQ - 1);
      owner       <= '0;
    end else begin
      timeout_err <= 1'b0;
      blocked     <= blocked & bus.req;
      case (state)
        S_POWERUP: begin
          data_q <= 8'h00;
          if (pu_cnt == PU_W'(POWERUP_TICKS - 1)) state <= S_INIT;
          else pu_cnt <= pu_cnt + 1'b1;
        end
        S_INIT: begin
          if (init_idx == INIT_LEN) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
            data_q    <= 8'h00;
          end else begin
            data_q   <= init_cmd(init_idx);
            init_idx <= init_idx + 3'd1;
          end
        end
        S_IDLE: begin
          data_q <= 8'h00;
          if (win_valid) begin
            grant_q  <= win_onehot;
            owner    <= win_idx;
            ptr      <= win_idx;
            hold_cnt <= '0;
            state    <= S_OWNED;
          end
        end
        S_OWNED: begin
          if (!bus.req[owner]) begin
            grant_q <= '0;
            state   <= S_GAP;
          end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
            grant_q        <= '0;
            timeout_err    <= 1'b1;
            blocked[owner] <= 1'b1;
            state          <= S_GAP;
          end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_GAP: begin
          data_q <= 8'h00;
          state  <= S_IDLE;
        end
        default: state <= S_POWERUP;
      endcase
    end
  end

  assign owned     = |grant_q;
  assign bus.grant = grant_q;
  assign rw        = 1'b0;
  assign rs        = owned ? bus.req_rs[owner] : 1'b0;
  assign data      = owned ? bus.req_data[{owner, 3'b000} +: 8] : data_q;

endmodule

// File: tb/tb_lcd1602_bus_sched.sv
// Directed bench for lcd1602_bus_sched: init sequence, single client, round-robin,
// watchdog revoke, release/contend and reset while owned.
module tb_lcd1602_bus_sched;

  logic       clk;
  logic       reset;
  logic       init_done;
  logic       timeout_err;
  logic       rs;
  logic       rw;
  logic [7:0] data;

  int errors = 0;
  int checks = 0;

  lcd1602_bus_sched_if #(.NUM_REQ(2)) bus ();

  lcd1602_bus_sched #(
    .NUM_REQ       (2),
    .POWERUP_TICKS (3),
    .MAX_HOLD      (8)
  ) dut (
    .clk_16ms    (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .init_done   (init_done),
    .timeout_err (timeout_err),
    .rs          (rs),
    .rw          (rw),
    .data        (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects reset just released with client 0 requesting (rs=1, data byte d0).
  task automatic init_seq(input logic [7:0] d0);
    logic [7:0] cmds [5];
    cmds[0] = 8'h38; cmds[1] = 8'h38; cmds[2] = 8'h0C; cmds[3] = 8'h01; cmds[4] = 8'h06;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pu_grant", bus.grant, 2'b00);
      chk("pu_data", data, 8'h00);
      chk("pu_init_done", init_done, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("init_data", data, cmds[i]);
      chk("init_rs", rs, 1'b0);
      chk("init_grant", bus.grant, 2'b00);
      chk("init_done_low", init_done, 1'b0);
    end
    tick();
    chk("init_done", init_done, 1'b1);
    chk("init_done_data", data, 8'h00);
    chk("init_done_grant", bus.grant, 2'b00);
    tick();
    chk("first_grant", bus.grant, 2'b01);
    chk("first_rs", rs, 1'b1);
    chk("first_data", data, d0);
  endtask

  logic [7:0] rr_data [2];
  logic       rr_rs   [2];

  initial begin
    reset        = 1'b0;
    bus.req      = 2'b00;
    bus.req_rs   = 2'b00;
    bus.req_data = 16'h0000;
    tick();
    tick();
    chk("rst_grant", bus.grant, 2'b00);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_rs", rs, 1'b0);
    chk("rst_rw", rw, 1'b0);
    chk("rst_data", data, 8'h00);

    // power-up with both clients requesting throughout
    reset        = 1'b1;
    bus.req      = 2'b11;
    bus.req_rs   = 2'b11;
    bus.req_data = {8'h22, 8'h11};
    init_seq(8'h11);
    bus.req = 2'b00;
    tick();
    chk("rel_gap_grant", bus.grant, 2'b00);
    chk("rel_gap_data", data, 8'h00);
    tick();

    // single client 1
    bus.req      = 2'b10;
    bus.req_rs   = 2'b10;
    bus.req_data = {8'h41, 8'h00};
    tick();
    chk("single_grant", bus.grant, 2'b10);
    chk("single_rs", rs, 1'b1);
    chk("single_data", data, 8'h41);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("single_hold_grant", bus.grant, 2'b10);
      chk("single_hold_data", data, 8'h41);
    end
    bus.req = 2'b00;
    tick();
    chk("single_gap_grant", bus.grant, 2'b00);
    chk("single_gap_data", data, 8'h00);
    chk("single_gap_rs", rs, 1'b0);
    chk("single_rw", rw, 1'b0);
    tick();
    chk("single_idle_grant", bus.grant, 2'b00);

    // round-robin, both clients contending
    bus.req_data = {8'hB2, 8'hA1};
    bus.req_rs   = 2'b01;
    rr_data[0] = 8'hA1; rr_data[1] = 8'hB2;
    rr_rs[0]   = 1'b1;  rr_rs[1]   = 1'b0;
    bus.req = 2'b11;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("rr_grant", bus.grant, 32'(1) << (r % 2));
      chk("rr_data", data, rr_data[r % 2]);
      chk("rr_rs", rs, rr_rs[r % 2]);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("rr_hold", bus.grant, 32'(1) << (r % 2));
      end
      bus.req[r % 2] = 1'b0;
      tick();
      chk("rr_gap_grant", bus.grant, 2'b00);
      chk("rr_gap_data", data, 8'h00);
      bus.req[r % 2] = 1'b1;
      tick();
      chk("rr_idle_grant", bus.grant, 2'b00);
    end

    // watchdog: client 0 never releases
    bus.req = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("wd_owned_grant", bus.grant, 2'b01);
      chk("wd_no_timeout", timeout_err, 1'b0);
      if (i == 2) bus.req = 2'b11;
    end
    tick();
    chk("wd_revoke_grant", bus.grant, 2'b00);
    chk("wd_timeout_pulse", timeout_err, 1'b1);
    chk("wd_revoke_data", data, 8'h00);
    tick();
    chk("wd_timeout_clear", timeout_err, 1'b0);
    chk("wd_gap_grant", bus.grant, 2'b00);
    tick();
    chk("wd_other_grant", bus.grant, 2'b10);
    chk("wd_other_data", data, 8'hB2);
    tick();
    chk("wd_other_hold", bus.grant, 2'b10);
    bus.req[1] = 1'b0;
    tick();
    chk("wd_other_gap", bus.grant, 2'b00);
    tick();
    tick();
    chk("wd_blocked_1", bus.grant, 2'b00);
    tick();
    chk("wd_blocked_2", bus.grant, 2'b00);
    bus.req[0] = 1'b0;
    tick();
    chk("wd_dropped", bus.grant, 2'b00);
    bus.req[0] = 1'b1;
    tick();
    chk("wd_regrant", bus.grant, 2'b01);

    // owner releases on the same edge the other client raises
    bus.req = 2'b10;
    tick();
    chk("contend_gap", bus.grant, 2'b00);
    chk("contend_gap_data", data, 8'h00);
    tick();
    chk("contend_idle", bus.grant, 2'b00);
    tick();
    chk("contend_grant", bus.grant, 2'b10);

    // reset while client 0 owns the bus
    bus.req = 2'b01;
    tick();
    tick();
    tick();
    chk("pre_reset_grant", bus.grant, 2'b01);
    chk("pre_reset_data", data, 8'hA1);
    reset = 1'b0;
    tick();
    chk("midrst_grant", bus.grant, 2'b00);
    chk("midrst_rs", rs, 1'b0);
    chk("midrst_data", data, 8'h00);
    chk("midrst_init_done", init_done, 1'b0);
    reset = 1'b1;
    init_seq(8'hA1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
